// File: rtl/mem_arb_pkg.sv
// Shared encodings for the CPU/debug data-memory arbiter.
// State and grant encodings are fixed so other blocks can decode them consistently.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_CPU = 1'b0,
        GNT_DBG = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of an async-read data memory.
// Each access takes three cycles: IDLE (arbitrate), ACCESS (drive memory) and DONE (ack).
module mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              cpu_err,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [31:0]       dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_a,
    output logic [DATA_W-1:0] mem_d,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_spo,
    output logic              busy
);
    import mem_arb_pkg::*;

    arb_state_t        state, state_next;
    grant_t            last_grant, grant_q, grant_sel;
    logic              we_q, err_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] wdata_q;

    logic              any_req;
    logic              cpu_misaligned;
    logic [ADDR_W-1:0] cpu_idx, dbg_idx;
    logic              unused_addr_bits;

    assign any_req          = cpu_req | dbg_req;
    assign cpu_misaligned   = (cpu_addr[1:0] != 2'b00);
    assign cpu_idx          = cpu_addr[ADDR_W+1:2];
    assign dbg_idx          = dbg_addr[ADDR_W-1:0];
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], dbg_addr[31:ADDR_W]};

    assign mem_a = idx_q;
    assign mem_d = wdata_q;
    assign busy  = (state != IDLE);

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_sel = GNT_CPU;
        if (cpu_req && dbg_req) begin
            grant_sel = (last_grant == GNT_CPU) ? GNT_DBG : GNT_CPU;
        end else if (dbg_req) begin
            grant_sel = GNT_DBG;
        end
    end

    always_comb begin
        state_next = state;
        mem_we     = 1'b0;
        cpu_ack    = 1'b0;
        dbg_ack    = 1'b0;
        cpu_err    = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                state_next = DONE;
                mem_we     = we_q & ~err_q;
            end
            DONE: begin
                state_next = IDLE;
                cpu_ack    = (grant_q == GNT_CPU);
                dbg_ack    = (grant_q == GNT_DBG);
                cpu_err    = (grant_q == GNT_CPU) & err_q;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Request payload is frozen at grant time so requesters may change inputs while waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GNT_DBG;
            grant_q    <= GNT_CPU;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
        end else if (state == IDLE && any_req) begin
            last_grant <= grant_sel;
            grant_q    <= grant_sel;
            if (grant_sel == GNT_CPU) begin
                we_q    <= cpu_we;
                err_q   <= cpu_misaligned;
                idx_q   <= cpu_idx;
                wdata_q <= cpu_wdata;
            end else begin
                we_q    <= dbg_we;
                err_q   <= 1'b0;
                idx_q   <= dbg_idx;
                wdata_q <= dbg_wdata;
            end
        end
    end

    // Read data (old contents on a write) lands at the end of ACCESS; a faulted CPU access keeps its rdata.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata <= '0;
            dbg_rdata <= '0;
        end else if (state == ACCESS) begin
            if (grant_q == GNT_DBG) begin
                dbg_rdata <= mem_spo;
            end else if (!err_q) begin
                cpu_rdata <= mem_spo;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level model of arbitration and memory.
module tb_mem_arbiter;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0]       cpu_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic              cpu_ack, cpu_err;
    logic [DATA_W-1:0] cpu_rdata;
    logic              dbg_req = 1'b0, dbg_we = 1'b0;
    logic [31:0]       dbg_addr = '0;
    logic [DATA_W-1:0] dbg_wdata = '0;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] mem_a;
    logic [DATA_W-1:0] mem_d;
    logic              mem_we;
    logic [DATA_W-1:0] mem_spo;
    logic              busy;

    logic [DATA_W-1:0] mem [DEPTH];

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External memory: asynchronous read, synchronous write.
    assign mem_spo = mem[mem_a];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_d;
    end

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level reference model state.
    int                edge_no = 0;
    int                next_accept = 0;
    int                acc_edge = -10;
    bit                acc_dbg, acc_we, acc_err;
    int                acc_idx;
    logic [DATA_W-1:0] acc_wdata;
    bit                last_dbg = 1'b1;
    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_cpu_rd = '0;
    logic [DATA_W-1:0] exp_dbg_rd = '0;

    bit cpu_hold = 1'b0, dbg_hold = 1'b0, rand_mode = 1'b0;
    int cpu_ack_edge = -1, dbg_ack_edge = -1;
    int ack_log [$];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", tag, got, want, edge_no);
        end
    endtask

    task automatic new_cpu_payload();
        logic [31:0] r;
        logic [7:0]  idx;
        logic [1:0]  low;
        r   = $urandom();
        idx = 8'($urandom_range(0, 7));
        low = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        cpu_addr  = {r[31:10], idx, low};
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_wdata = $urandom();
    endtask

    task automatic new_dbg_payload();
        logic [31:0] r;
        logic [7:0]  idx;
        r   = $urandom();
        idx = 8'($urandom_range(0, 7));
        dbg_addr  = {r[31:8], idx};
        dbg_we    = 1'($urandom_range(0, 1));
        dbg_wdata = $urandom();
    endtask

    // Model update at each rising edge from the requests sampled there.
    task automatic model_edge();
        edge_no++;
        if (rst) begin
            last_dbg    = 1'b1;
            exp_cpu_rd  = '0;
            exp_dbg_rd  = '0;
            acc_edge    = -10;
            next_accept = edge_no + 1;
            return;
        end
        if (edge_no == acc_edge + 1) begin
            if (acc_dbg) exp_dbg_rd = ref_mem[acc_idx];
            else if (!acc_err) exp_cpu_rd = ref_mem[acc_idx];
            if (acc_we && !acc_err) ref_mem[acc_idx] = acc_wdata;
        end
        if (edge_no >= next_accept && (cpu_req || dbg_req)) begin
            acc_dbg = (cpu_req && dbg_req) ? !last_dbg : dbg_req;
            if (acc_dbg) begin
                acc_we    = dbg_we;
                acc_idx   = int'(dbg_addr % DEPTH);
                acc_wdata = dbg_wdata;
                acc_err   = 1'b0;
            end else begin
                acc_we    = cpu_we;
                acc_idx   = int'((cpu_addr / 4) % DEPTH);
                acc_wdata = cpu_wdata;
                acc_err   = (cpu_addr % 4) != 0;
            end
            last_dbg    = acc_dbg;
            acc_edge    = edge_no;
            next_accept = edge_no + 3;
        end
    endtask

    task automatic check_interval();
        bit in_acc, in_done, exp_we;
        in_acc  = (edge_no == acc_edge);
        in_done = (edge_no == acc_edge + 1);
        exp_we  = in_acc && acc_we && !acc_err;
        checkOutput("busy", busy, in_acc || in_done);
        checkOutput("mem_we", mem_we, exp_we);
        if (in_acc) checkOutput("mem_a", mem_a, acc_idx);
        if (exp_we) checkOutput("mem_d", mem_d, acc_wdata);
        checkOutput("cpu_ack", cpu_ack, in_done && !acc_dbg);
        checkOutput("dbg_ack", dbg_ack, in_done && acc_dbg);
        checkOutput("cpu_err", cpu_err, in_done && !acc_dbg && acc_err);
        checkOutput("cpu_rdata", cpu_rdata, exp_cpu_rd);
        checkOutput("dbg_rdata", dbg_rdata, exp_dbg_rd);
        if (cpu_ack) begin cpu_ack_edge = edge_no; ack_log.push_back(0); end
        if (dbg_ack) begin dbg_ack_edge = edge_no; ack_log.push_back(1); end
    endtask

    // Requesters: hold req until acked, then drop it (or re-arm when holding continuously).
    task automatic applyStimulus();
        if (cpu_req && cpu_ack) begin
            if (cpu_hold) new_cpu_payload();
            else cpu_req = 1'b0;
        end else if (!cpu_req && rand_mode && $urandom_range(0, 3) == 0) begin
            cpu_req = 1'b1;
            new_cpu_payload();
        end
        if (dbg_req && dbg_ack) begin
            if (dbg_hold) new_dbg_payload();
            else dbg_req = 1'b0;
        end else if (!dbg_req && rand_mode && $urandom_range(0, 3) == 0) begin
            dbg_req = 1'b1;
            new_dbg_payload();
        end
        if (rand_mode) begin
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                cpu_req = 1'b0;
                dbg_req = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_interval();
        applyStimulus();
    endtask

    task automatic wait_ack(input bit want_dbg, output int at);
        at = -1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (want_dbg ? dbg_ack : cpu_ack) begin
                at = edge_no;
                break;
            end
        end
        if (at < 0) checkOutput(want_dbg ? "dbg_ack_timeout" : "cpu_ack_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        int at, start;
        logic [DATA_W-1:0] init_mem4, init_mem8;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = $urandom();
            ref_mem[i] = mem[i];
        end
        init_mem4 = ref_mem[4];
        init_mem8 = ref_mem[8];

        step();
        step();
        rst = 1'b0;
        step();
        checkOutput("reset_cpu_rdata", cpu_rdata, 32'h0);
        checkOutput("reset_busy", busy, 1'b0);

        // CPU write of DEADBEEF to byte address 0x10 (word 4)
        start = edge_no;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hDEADBEEF;
        wait_ack(1'b0, at);
        checkOutput("wr_ack_latency", at - start, 2);
        checkOutput("wr_err", cpu_err, 1'b0);
        checkOutput("wr_mem4", mem[4], 32'hDEADBEEF);
        step();

        // Debug read of word 4
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd4;
        wait_ack(1'b1, at);
        checkOutput("dbg_rd_data", dbg_rdata, 32'hDEADBEEF);
        checkOutput("dbg_rd_cpu_rdata", cpu_rdata, init_mem4);
        step();

        // Simultaneous requests after reset: CPU first, debug second
        pulse_reset();
        cpu_ack_edge = -1; dbg_ack_edge = -1;
        start = edge_no;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0020;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd8;
        for (int k = 0; k < 20 && (cpu_ack_edge < 0 || dbg_ack_edge < 0); k++) step();
        checkOutput("tie_cpu_ack", cpu_ack_edge - start, 2);
        checkOutput("tie_dbg_ack", dbg_ack_edge - start, 5);
        checkOutput("tie_cpu_data", cpu_rdata, init_mem8);
        step();

        // Misaligned CPU write must fault without touching memory
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0013; cpu_wdata = 32'h1234_5678;
        wait_ack(1'b0, at);
        checkOutput("misalign_err", cpu_err, 1'b1);
        checkOutput("misalign_rdata", cpu_rdata, init_mem8);
        step();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd4;
        wait_ack(1'b1, at);
        checkOutput("misalign_mem4", dbg_rdata, 32'hDEADBEEF);
        step();

        // Reset during ACCESS aborts the write
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0010; cpu_wdata = 32'hCAFE_F00D;
        step();
        checkOutput("midrst_we_before", mem_we, 1'b1);
        rst = 1'b1;
        cpu_req = 1'b0;
        #1;
        checkOutput("midrst_we_drop", mem_we, 1'b0);
        checkOutput("midrst_busy", busy, 1'b0);
        checkOutput("midrst_ack", cpu_ack, 1'b0);
        step();
        rst = 1'b0;
        step();
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'd4;
        wait_ack(1'b1, at);
        checkOutput("midrst_old_data", dbg_rdata, 32'hDEADBEEF);
        step();

        // Saturation: both requesters held for 12 cycles
        pulse_reset();
        ack_log.delete();
        cpu_hold = 1'b1; dbg_hold = 1'b1;
        cpu_req = 1'b1; new_cpu_payload();
        dbg_req = 1'b1; new_dbg_payload();
        for (int k = 0; k < 12; k++) begin
            step();
            checkOutput($sformatf("sat_busy%0d", k), busy, (k % 3) != 2);
        end
        cpu_hold = 1'b0; dbg_hold = 1'b0;
        cpu_req = 1'b0; dbg_req = 1'b0;
        checkOutput("sat_grants", ack_log.size(), 4);
        for (int i = 0; i < ack_log.size(); i++) begin
            checkOutput($sformatf("sat_order%0d", i), ack_log[i], i % 2);
        end
        step();

        // Randomized traffic with occasional resets
        rand_mode = 1'b1;
        repeat (600) step();
        rand_mode = 1'b0;
        rst = 1'b0;
        cpu_req = 1'b0; dbg_req = 1'b0;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
